// File: rtl/bus_cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bus_cycle_sequencer_if
//  Purpose  : Host request, multiplexed external bus and readback signals
//             shared between bus_cycle_sequencer and its host.
//  Revision : 1.0 - initial release
// ============================================================================
interface bus_cycle_sequencer_if #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic              pause;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;
    logic              ALE;
    logic              En;
    logic              Rw;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [SEL_W-1:0]  regSelect;
    logic [DATA_W-1:0] dispReg;

    modport slave (
        input  pause, req_valid, req_rw, req_addr, req_wdata, ad_in, regSelect,
        output req_ready, ad_out, ad_oe, ALE, En, Rw, rsp_valid, rsp_rdata, dispReg
    );

    modport master (
        output pause, req_valid, req_rw, req_addr, req_wdata, ad_in, regSelect,
        input  req_ready, ad_out, ad_oe, ALE, En, Rw, rsp_valid, rsp_rdata, dispReg
    );
endinterface
`default_nettype wire

// File: rtl/bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : bus_cycle_sequencer
//  Purpose  : Runs ADDR/SETUP/STROBE/HOLD cycles on a multiplexed A/D bus and
//             keeps a small bank of readback registers fed by read data.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_cycle_sequencer #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int ALE_CYC  = 2,
    parameter int EN_CYC   = 3,
    parameter int NUM_REGS = 4
) (
    input wire                 clk,
    input wire                 rst,
    bus_cycle_sequencer_if.slave bus
);
    localparam int SEL_W     = $clog2(NUM_REGS);
    localparam int c_MAX_CYC = (ALE_CYC > EN_CYC) ? ALE_CYC : EN_CYC;
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_ALE_LAST = c_CNT_W'(ALE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_EN_LAST  = c_CNT_W'(EN_CYC - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ADDR   = 3'd1;
    localparam logic [2:0] c_SETUP  = 3'd2;
    localparam logic [2:0] c_STROBE = 3'd3;
    localparam logic [2:0] c_HOLD   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_ad_out;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [DATA_W-1:0]  r_regs [NUM_REGS];

    logic               w_accept;
    logic               w_to_setup;
    logic               w_capture;
    logic [SEL_W-1:0]   w_sel;

    // Acceptance ignores rst: the state register is held in reset anyway.
    assign w_accept   = (r_state == c_IDLE) && !bus.pause && bus.req_valid;
    assign w_to_setup = (r_state == c_ADDR) && !bus.pause && (r_cnt == c_ALE_LAST);
    assign w_capture  = (r_state == c_STROBE) && !bus.pause && (r_cnt == c_EN_LAST) && r_rw;
    assign w_sel      = SEL_W'(r_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!bus.pause) begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = c_ADDR;
                        w_cnt_nxt   = '0;
                    end
                end
                c_ADDR: begin
                    if (r_cnt == c_ALE_LAST) begin
                        w_state_nxt = c_SETUP;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                c_SETUP: begin
                    w_state_nxt = c_STROBE;
                    w_cnt_nxt   = '0;
                end
                c_STROBE: begin
                    if (r_cnt == c_EN_LAST) begin
                        w_state_nxt = c_HOLD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                c_HOLD:  w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.ALE       = 1'b0;
        bus.En        = 1'b0;
        bus.ad_oe     = 1'b0;
        bus.Rw        = 1'b1;
        bus.rsp_valid = 1'b0;
        case (r_state)
            c_IDLE:   bus.req_ready = !bus.pause && !rst;
            c_ADDR: begin
                bus.ALE   = 1'b1;
                bus.ad_oe = 1'b1;
                bus.Rw    = r_rw;
            end
            c_SETUP: begin
                bus.ad_oe = !r_rw;
                bus.Rw    = r_rw;
            end
            c_STROBE: begin
                bus.En    = 1'b1;
                bus.ad_oe = !r_rw;
                bus.Rw    = r_rw;
            end
            c_HOLD: begin
                bus.ad_oe     = !r_rw;
                bus.Rw        = r_rw;
                bus.rsp_valid = r_rw;
            end
            default: ;
        endcase
    end

    // ad_out is registered so it keeps its last driven value through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw        <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ad_out    <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_rw     <= bus.req_rw;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_ad_out <= DATA_W'(bus.req_addr);
            end
            if (w_to_setup && !r_rw) begin
                r_ad_out <= r_wdata;
            end
            if (w_capture) begin
                r_rsp_rdata <= bus.ad_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_capture) begin
            r_regs[w_sel] <= bus.ad_in;
        end
    end

    assign bus.ad_out    = r_ad_out;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.dispReg   = r_regs[bus.regSelect];

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_cycle_sequencer
//  Purpose  : Directed and random stimulus for bus_cycle_sequencer, checked
//             against a phase-timeline model of a bus transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_sequencer;
    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 8;
    localparam int c_ALE    = 2;
    localparam int c_EN     = 3;
    localparam int c_NREGS  = 4;
    localparam int c_LAST   = c_ALE + c_EN + 1;   // phase index of HOLD

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_cycle_sequencer_if #(.DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W), .NUM_REGS(c_NREGS)) bus ();

    bus_cycle_sequencer #(
        .DATA_W(c_DATA_W), .ADDR_W(c_ADDR_W), .ALE_CYC(c_ALE),
        .EN_CYC(c_EN), .NUM_REGS(c_NREGS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction model: m_p counts completed unpaused cycles since ADDR began.
    bit         m_busy;
    int         m_p;
    bit         m_rw;
    logic [7:0] m_addr, m_wdata, m_rdata, m_adout;
    bit         m_adout_known;
    logic [7:0] m_regs [c_NREGS];
    int         en_cnt, busy_cnt, rsp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_p = 0;
        m_rdata = 8'h00;
        m_adout = 8'h00;
        m_adout_known = 1'b1;
        for (int i = 0; i < c_NREGS; i++) m_regs[i] = 8'h00;
    endtask

    task automatic check_outputs();
        logic e_ale, e_en, e_oe, e_rw, e_rsp, e_rdy;
        if (!m_busy) begin
            e_ale = 1'b0; e_en = 1'b0; e_oe = 1'b0; e_rw = 1'b1; e_rsp = 1'b0;
            e_rdy = !bus.pause;
        end else begin
            e_ale = (m_p < c_ALE);
            e_en  = (m_p > c_ALE) && (m_p <= c_ALE + c_EN);
            e_oe  = (m_p < c_ALE) || !m_rw;
            e_rw  = m_rw;
            e_rsp = (m_p == c_LAST) && m_rw;
            e_rdy = 1'b0;
        end
        chk("ALE", bus.ALE, e_ale);
        chk("En", bus.En, e_en);
        chk("ad_oe", bus.ad_oe, e_oe);
        chk("rsp_valid", bus.rsp_valid, e_rsp);
        chk("req_ready", bus.req_ready, e_rdy);
        if (!m_busy || m_p >= c_ALE) chk("Rw", bus.Rw, e_rw);
        if (m_busy && e_oe) chk("ad_out", bus.ad_out, (m_p < c_ALE) ? m_addr : m_wdata);
        if (!m_busy && m_adout_known) chk("ad_out_idle", bus.ad_out, m_adout);
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("dispReg", bus.dispReg, m_regs[bus.regSelect]);
        if (bus.En) en_cnt++;
        if (!bus.req_ready) busy_cnt++;
        if (bus.rsp_valid) rsp_cnt++;
    endtask

    task automatic model_step();
        if (bus.pause) return;
        if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy = 1'b1; m_p = 0; m_rw = bus.req_rw;
                m_addr = bus.req_addr; m_wdata = bus.req_wdata;
            end
        end else begin
            if (m_p == c_ALE + c_EN && m_rw) begin
                m_rdata = bus.ad_in;
                m_regs[m_addr % c_NREGS] = bus.ad_in;
            end
            if (m_p == c_LAST) begin
                m_busy = 1'b0;
                m_adout_known = !m_rw;
                if (!m_rw) m_adout = m_wdata;
            end else begin
                m_p++;
            end
        end
    endtask

    task automatic cycle(input bit p, input bit v, input bit rw, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] din, input logic [1:0] sel);
        bus.pause = p; bus.req_valid = v; bus.req_rw = rw; bus.req_addr = a;
        bus.req_wdata = d; bus.ad_in = din; bus.regSelect = sel;
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
    endtask

    task automatic clear_counts();
        en_cnt = 0; busy_cnt = 0; rsp_cnt = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.pause = 1'b0; bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = 8'h00;
        bus.req_wdata = 8'h00; bus.ad_in = 8'h00; bus.regSelect = 2'd0;
        model_reset();
        clear_counts();
        @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_ALE", bus.ALE, 1'b0);
        chk("rst_En", bus.En, 1'b0);
        chk("rst_ad_oe", bus.ad_oe, 1'b0);
        chk("rst_Rw", bus.Rw, 1'b1);
        chk("rst_ad_out", bus.ad_out, 8'h00);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write 0x12 <- 0xA5
        clear_counts();
        cycle(1'b0, 1'b1, 1'b0, 8'h12, 8'hA5, 8'h00, 2'd0);
        idle(8);
        chk("wr_busy_cycles", busy_cnt, 7);
        chk("wr_en_cycles", en_cnt, 3);
        chk("wr_rsp_count", rsp_cnt, 0);

        // Read 0x06 returning 0x3C, viewed through regSelect = 2
        clear_counts();
        cycle(1'b0, 1'b1, 1'b1, 8'h06, 8'h00, 8'h3C, 2'd2);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 2'd2);
        chk("rd_rsp_count", rsp_cnt, 1);
        chk("rd_dispReg2", bus.dispReg, 8'h3C);
        chk("rd_rsp_rdata", bus.rsp_rdata, 8'h3C);

        // Pause for 4 cycles during the 2nd STROBE cycle of a read
        clear_counts();
        cycle(1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 8'h5A, 2'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 2'd1);
        chk("pause_en_cycles", en_cnt, 7);
        chk("pause_busy_cycles", busy_cnt, 11);
        chk("pause_rsp_count", rsp_cnt, 1);

        // Back-to-back with req_valid held high and payload changing every cycle
        for (int i = 0; i < 16; i++)
            cycle(1'b0, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
        idle(8);

        // Pause in IDLE with a pending request
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 8'h03, 8'h00, 8'h77, 2'd3);
        cycle(1'b0, 1'b1, 1'b1, 8'h03, 8'h00, 8'h77, 2'd3);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 2'd3);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(3) == 0), 1'($urandom), 1'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), 2'($urandom));
        idle(12);

        // Reset during STROBE of a read
        cycle(1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'hC3, 2'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 2'd2);
        chk("pre_rst_En", bus.En, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_En", bus.En, 1'b0);
        chk("arst_ad_oe", bus.ad_oe, 1'b0);
        chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("arst_req_ready", bus.req_ready, 1'b0);
        chk("arst_ad_out", bus.ad_out, 8'h00);
        for (int s = 0; s < c_NREGS; s++) begin
            bus.regSelect = 2'(s);
            #1;
            chk("arst_dispReg", bus.dispReg, 8'h00);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_counts();
        idle(4);
        chk("post_rst_rsp_count", rsp_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
